imem_fetch: RTL and testbench

Instruction-fetch stage for the 5-stage RV32I pipeline and the requester side of the instruction memory. It owns the PC, drives the word-aligned fetch address to the combinational instruction memory, and captures the returned word into the IF/ID pipeline register. It also applies stall, flush and branch/jump redirects from the hazard unit and execute stage. A two-state FSM stops fetching on out-of-range or misaligned PCs.

---
 rtl/imem_fetch_if.sv | 8 +
 rtl/imem_fetch.sv | 91 +++++++++
 tb/tb_imem_fetch.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_if.sv
// Requester/responder bus between the fetch stage and the combinational instruction memory.
interface imem_fetch_if;
    logic [31:0] imem_a;
    logic [31:0] imem_rd;

    modport master (output imem_a, input imem_rd);
    modport slave  (input imem_a, output imem_rd);
endinterface

// File: rtl/imem_fetch.sv
// RV32I instruction-fetch stage: owns the PC, reads the combinational imem and fills IF/ID.
// Stops fetching on out-of-range PCs or misaligned redirect targets until redirected or reset.
module imem_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 64,
    parameter logic [31:0] NOP        = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         reset,
    imem_fetch_if.master imem,
    input  logic         stall_f,
    input  logic         stall_d,
    input  logic         flush_d,
    input  logic         pcsrc_e,
    input  logic [31:0]  pctarget_e,
    output logic [31:0]  pc_f,
    output logic [31:0]  instr_d,
    output logic [31:0]  pc_d,
    output logic [31:0]  pcplus4_d,
    output logic         valid_d,
    output logic         fault,
    output logic [1:0]   fault_cause,
    output logic [31:0]  fault_pc,
    output logic [31:0]  fetch_count
);

    typedef enum logic {
        S_RUN,
        S_FAULT
    } state_t;

    localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_WORDS);

    state_t      state;
    logic        in_range;
    logic [31:0] pc_plus4;

    assign imem.imem_a = pc_f;
    assign in_range    = (pc_f < PC_LIMIT);
    assign pc_plus4    = pc_f + 32'd4;
    assign fault       = (state == S_FAULT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_RUN;
            pc_f        <= RESET_PC;
            instr_d     <= NOP;
            pc_d        <= '0;
            pcplus4_d   <= '0;
            valid_d     <= 1'b0;
            fault_cause <= 2'b00;
            fault_pc    <= '0;
            fetch_count <= '0;
        end else begin
            // Fault detection on an out-of-range PC is independent of stall_f; the PC holds either way.
            if (pcsrc_e) begin
                if (pctarget_e[1:0] == 2'b00) begin
                    pc_f  <= pctarget_e;
                    state <= S_RUN;
                end else begin
                    state       <= S_FAULT;
                    fault_cause <= 2'b10;
                    fault_pc    <= pctarget_e;
                end
            end else if (state == S_RUN && !in_range) begin
                state       <= S_FAULT;
                fault_cause <= 2'b01;
                fault_pc    <= pc_f;
            end else if (!stall_f && state == S_RUN) begin
                pc_f <= pc_plus4;
            end

            if (flush_d || pcsrc_e) begin
                instr_d <= NOP;
                valid_d <= 1'b0;
            end else if (stall_d) begin
                instr_d <= instr_d;
            end else if (stall_f || state != S_RUN || !in_range) begin
                instr_d <= NOP;
                valid_d <= 1'b0;
            end else begin
                instr_d     <= imem.imem_rd;
                pc_d        <= pc_f;
                pcplus4_d   <= pc_plus4;
                valid_d     <= 1'b1;
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch.sv
// Bench for imem_fetch: directed vector table followed by random stimulus against a rule-level model.
module tb_imem_fetch;

    localparam logic [31:0] NOPI = 32'h0000_0013;
    localparam logic [31:0] LIM  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset, stall_f, stall_d, flush_d, pcsrc_e;
    logic [31:0] pctarget_e;
    logic [31:0] pc_f, instr_d, pc_d, pcplus4_d, fault_pc, fetch_count;
    logic        valid_d, fault;
    logic [1:0]  fault_cause;

    int errors = 0;
    int checks = 0;

    imem_fetch_if bus ();

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a < LIM) ? 32'h1000_0000 + (a >> 2) : 32'hDEAD_BEEF;
    endfunction

    assign bus.imem_rd = mem_word(bus.imem_a);

    imem_fetch #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (64),
        .NOP        (NOPI)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (bus.master),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .pcsrc_e     (pcsrc_e),
        .pctarget_e  (pctarget_e),
        .pc_f        (pc_f),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pcplus4_d   (pcplus4_d),
        .valid_d     (valid_d),
        .fault       (fault),
        .fault_cause (fault_cause),
        .fault_pc    (fault_pc),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic [31:0] p4;
        logic        valid;
        logic        flt;
        logic [1:0]  cause;
        logic [31:0] fpc;
        logic [31:0] cnt;
    } exp_t;

    typedef struct {
        logic        rst, sf, sd, fl, ps;
        logic [31:0] tgt;
        exp_t        e;
    } vec_t;

    function automatic vec_t v(logic rst, logic sf, logic sd, logic fl, logic ps, logic [31:0] tgt,
                               logic [31:0] pc, logic [31:0] ins, logic [31:0] pcd, logic [31:0] p4,
                               logic vl, logic ft, logic [1:0] ca, logic [31:0] fp, logic [31:0] cnt);
        vec_t r;
        r.rst = rst; r.sf = sf; r.sd = sd; r.fl = fl; r.ps = ps; r.tgt = tgt;
        r.e.pc = pc; r.e.instr = ins; r.e.pcd = pcd; r.e.p4 = p4; r.e.valid = vl;
        r.e.flt = ft; r.e.cause = ca; r.e.fpc = fp; r.e.cnt = cnt;
        return r;
    endfunction

    task automatic chk(string tag, string what, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %h want %h", tag, what, act, exp);
        end
    endtask

    task automatic check_all(string tag, exp_t e);
        chk(tag, "pc_f", pc_f, e.pc);
        chk(tag, "imem_a", bus.imem_a, e.pc);
        chk(tag, "instr_d", instr_d, e.instr);
        chk(tag, "pc_d", pc_d, e.pcd);
        chk(tag, "pcplus4_d", pcplus4_d, e.p4);
        chk(tag, "valid_d", {31'd0, valid_d}, {31'd0, e.valid});
        chk(tag, "fault", {31'd0, fault}, {31'd0, e.flt});
        chk(tag, "fault_cause", {30'd0, fault_cause}, {30'd0, e.cause});
        chk(tag, "fault_pc", fault_pc, e.fpc);
        chk(tag, "fetch_count", fetch_count, e.cnt);
    endtask

    task automatic drive(logic rst, logic sf, logic sd, logic fl, logic ps, logic [31:0] tgt);
        reset = rst; stall_f = sf; stall_d = sd; flush_d = fl; pcsrc_e = ps; pctarget_e = tgt;
    endtask

    // Reference model: applies the stage rules to an abstract snapshot of the architectural state.
    function automatic exp_t model_step(exp_t s, logic rst, logic sf, logic sd, logic fl,
                                        logic ps, logic [31:0] tgt);
        exp_t n;
        logic can_fetch;
        if (rst) begin
            n = '{32'h0, NOPI, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0};
            return n;
        end
        n = s;
        can_fetch = !s.flt && (s.pc < LIM) && !sf;
        if (ps) begin
            if (tgt % 4 == 0) begin
                n.pc = tgt; n.flt = 1'b0;
            end else begin
                n.flt = 1'b1; n.cause = 2'd2; n.fpc = tgt;
            end
        end else if (!s.flt && s.pc >= LIM) begin
            n.flt = 1'b1; n.cause = 2'd1; n.fpc = s.pc;
        end else if (!s.flt && !sf) begin
            n.pc = s.pc + 4;
        end
        if (fl || ps) begin
            n.instr = NOPI; n.valid = 1'b0;
        end else if (!sd) begin
            if (can_fetch) begin
                n.instr = mem_word(s.pc); n.pcd = s.pc; n.p4 = s.pc + 4;
                n.valid = 1'b1; n.cnt = s.cnt + 1;
            end else begin
                n.instr = NOPI; n.valid = 1'b0;
            end
        end
        return n;
    endfunction

    function automatic logic [31:0] w(int unsigned i);
        return 32'h1000_0000 + i;
    endfunction

    vec_t vq[$];
    exp_t m;

    initial begin
        drive(1, 0, 0, 0, 0, 0);

        // rst sf sd fl ps tgt | pc instr pc_d pc+4 valid fault cause fault_pc count
        vq.push_back(v(1,0,0,0,0,0,      32'h0,  NOPI,    32'h0,  32'h0,   0,0,0,32'h0,  0));
        vq.push_back(v(0,0,0,0,0,0,      32'h4,  w(0),    32'h0,  32'h4,   1,0,0,32'h0,  1));
        vq.push_back(v(0,0,0,0,0,0,      32'h8,  w(1),    32'h4,  32'h8,   1,0,0,32'h0,  2));
        vq.push_back(v(0,0,0,0,0,0,      32'hC,  w(2),    32'h8,  32'hC,   1,0,0,32'h0,  3));
        vq.push_back(v(0,1,1,0,0,0,      32'hC,  w(2),    32'h8,  32'hC,   1,0,0,32'h0,  3));
        vq.push_back(v(0,1,1,0,0,0,      32'hC,  w(2),    32'h8,  32'hC,   1,0,0,32'h0,  3));
        vq.push_back(v(0,1,1,0,0,0,      32'hC,  w(2),    32'h8,  32'hC,   1,0,0,32'h0,  3));
        vq.push_back(v(0,1,0,0,0,0,      32'hC,  NOPI,    32'h8,  32'hC,   0,0,0,32'h0,  3));
        vq.push_back(v(0,0,0,0,0,0,      32'h10, w(3),    32'hC,  32'h10,  1,0,0,32'h0,  4));
        vq.push_back(v(0,0,0,0,1,32'h20, 32'h20, NOPI,    32'hC,  32'h10,  0,0,0,32'h0,  4));
        vq.push_back(v(0,0,0,0,0,0,      32'h24, w(8),    32'h20, 32'h24,  1,0,0,32'h0,  5));
        vq.push_back(v(0,0,0,0,1,32'hF8, 32'hF8, NOPI,    32'h20, 32'h24,  0,0,0,32'h0,  5));
        vq.push_back(v(0,0,0,0,0,0,      32'hFC, w(62),   32'hF8, 32'hFC,  1,0,0,32'h0,  6));
        vq.push_back(v(0,0,0,0,0,0,      32'h100,w(63),   32'hFC, 32'h100, 1,0,0,32'h0,  7));
        vq.push_back(v(0,0,0,0,0,0,      32'h100,NOPI,    32'hFC, 32'h100, 0,1,1,32'h100,7));
        vq.push_back(v(0,0,0,0,0,0,      32'h100,NOPI,    32'hFC, 32'h100, 0,1,1,32'h100,7));
        vq.push_back(v(0,0,0,0,1,32'h0,  32'h0,  NOPI,    32'hFC, 32'h100, 0,0,1,32'h100,7));
        vq.push_back(v(0,0,0,0,0,0,      32'h4,  w(0),    32'h0,  32'h4,   1,0,1,32'h100,8));
        vq.push_back(v(0,0,0,0,1,32'h6,  32'h4,  NOPI,    32'h0,  32'h4,   0,1,2,32'h6,  8));
        vq.push_back(v(0,0,1,0,0,0,      32'h4,  NOPI,    32'h0,  32'h4,   0,1,2,32'h6,  8));
        vq.push_back(v(1,0,0,0,1,32'h40, 32'h0,  NOPI,    32'h0,  32'h0,   0,0,0,32'h0,  0));
        vq.push_back(v(0,0,0,0,0,0,      32'h4,  w(0),    32'h0,  32'h4,   1,0,0,32'h0,  1));
        vq.push_back(v(0,0,1,0,0,0,      32'h8,  w(0),    32'h0,  32'h4,   1,0,0,32'h0,  1));
        vq.push_back(v(0,0,1,0,1,32'h40, 32'h40, NOPI,    32'h0,  32'h4,   0,0,0,32'h0,  1));
        vq.push_back(v(0,0,0,1,0,0,      32'h44, NOPI,    32'h0,  32'h4,   0,0,0,32'h0,  1));
        vq.push_back(v(0,1,1,0,0,0,      32'h44, NOPI,    32'h0,  32'h4,   0,0,0,32'h0,  1));
        vq.push_back(v(1,1,1,0,0,0,      32'h0,  NOPI,    32'h0,  32'h0,   0,0,0,32'h0,  0));

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].sf, vq[i].sd, vq[i].fl, vq[i].ps, vq[i].tgt);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vq[i].e);
        end

        // Randomised phase; the model starts from the reset state left by the last vector.
        m = '{32'h0, NOPI, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0};
        for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
            logic        r, sf, sd, fl, ps;
            logic [31:0] tg;
            r  = ($urandom_range(0, 149) == 0);
            sf = ($urandom_range(0, 5) == 0);
            sd = ($urandom_range(0, 5) == 0);
            fl = ($urandom_range(0, 9) == 0);
            ps = ($urandom_range(0, 7) == 0);
            tg = 32'($urandom_range(0, 70)) * 4;
            if ($urandom_range(0, 6) == 0)
                tg = tg + 32'($urandom_range(1, 3));
            if (!m.flt && m.pc >= LIM)
                sf = 1'b0;
            drive(r, sf, sd, fl, ps, tg);
            m = model_step(m, r, sf, sd, fl, ps, tg);
            @(posedge clk);
            #1;
            check_all($sformatf("rnd%0d", cyc), m);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
